// File: rtl/vend_pkg.sv
// Shared definitions for the vending change-payout datapath:
// payout FSM state encoding and coin values expressed in nickel units.
package vend_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_SEL         = 3'd1,
        ST_DIME_WAIT   = 3'd2,
        ST_NICKEL_WAIT = 3'd3,
        ST_DONE        = 3'd4
    } state_e;

    // Coin face values in nickel units.
    localparam int DIME_NU   = 2;
    localparam int NICKEL_NU = 1;

endpackage

// File: rtl/coin_inventory.sv
// Saturating coin counter for one hopper. Refill and a single-coin
// decrement may land in the same cycle; both are applied, and the result
// clamps at the all-ones value of the counter.
module coin_inventory #(
    parameter int INV_W = 6,
    parameter int INIT  = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             refill_valid,
    input  logic [INV_W-1:0] refill_amt,
    input  logic             dec,
    output logic [INV_W-1:0] cnt,
    output logic             nonzero
);

    localparam logic [INV_W:0] CNT_MAX = {1'b0, {INV_W{1'b1}}};
    localparam logic [INV_W:0] ONE     = (INV_W+1)'(1);

    logic [INV_W-1:0] cnt_q;
    logic [INV_W-1:0] cnt_d;
    logic [INV_W:0]   sum_add;
    logic [INV_W:0]   sum_net;

    // Next count: add refill in a widened sum, take off the ejected coin,
    // then clamp. The zero guard only matters if dec arrives on an empty
    // counter, which the sequencer never allows.
    always_comb begin
        sum_add = {1'b0, cnt_q} + (refill_valid ? {1'b0, refill_amt} : '0);
        sum_net = (dec && (sum_add != '0)) ? (sum_add - ONE) : sum_add;
        cnt_d   = (sum_net > CNT_MAX) ? CNT_MAX[INV_W-1:0] : sum_net[INV_W-1:0];
    end

    // Count register, loaded with the initial stock on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= INV_W'(INIT);
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt     = cnt_q;
    assign nonzero = |cnt_q;

endmodule

// File: rtl/vend_change_sequencer.sv
// Change-payout sequencer: accepts an amount in nickel units, ejects coins
// one at a time through req/ack handshakes (dimes first, then nickels),
// tracks both hopper inventories and reports any unpaid shortfall.
// Optional build macro HOPPER_TIMEOUT_EN adds an ack watchdog with sticky
// per-hopper jam flags (dime_jam / nickel_jam ports).
module vend_change_sequencer
    import vend_pkg::*;
#(
    parameter int CREDIT_W    = 5,
    parameter int INV_W       = 6,
    parameter int DIME_INIT   = 20,
    parameter int NICKEL_INIT = 20
`ifdef HOPPER_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 255
`endif
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                change_valid,
    input  logic [CREDIT_W-1:0] change_amt,
    output logic                change_ready,
    output logic                dime_req,
    input  logic                dime_ack,
    output logic                nickel_req,
    input  logic                nickel_ack,
    input  logic                refill_valid,
    input  logic [INV_W-1:0]    refill_dimes,
    input  logic [INV_W-1:0]    refill_nickels,
    output logic [INV_W-1:0]    dime_cnt,
    output logic [INV_W-1:0]    nickel_cnt,
    output logic                exact_change_only,
    output logic                done,
    output logic [CREDIT_W-1:0] shortfall
`ifdef HOPPER_TIMEOUT_EN
    ,
    output logic                dime_jam,
    output logic                nickel_jam
`endif
);

    localparam logic [CREDIT_W-1:0] DIME_AMT   = CREDIT_W'(DIME_NU);
    localparam logic [CREDIT_W-1:0] NICKEL_AMT = CREDIT_W'(NICKEL_NU);

    state_e              state_q;
    state_e              state_d;
    logic [CREDIT_W-1:0] remaining_q;
    logic [CREDIT_W-1:0] remaining_d;
    logic [CREDIT_W-1:0] shortfall_q;
    logic [CREDIT_W-1:0] shortfall_d;
    logic                dime_req_q;
    logic                nickel_req_q;
    logic                done_q;

    logic                dime_dec;
    logic                nickel_dec;
    logic                dime_nz;
    logic                nickel_nz;
    logic                dime_avail;
    logic                nickel_avail;
    logic                dime_timeout;
    logic                nickel_timeout;

    // A coin is counted only when its hopper acks while its request is up;
    // the request is high exactly in the matching wait state.
    assign dime_dec   = (state_q == ST_DIME_WAIT)   && dime_ack;
    assign nickel_dec = (state_q == ST_NICKEL_WAIT) && nickel_ack;

`ifdef HOPPER_TIMEOUT_EN
    localparam int             WD_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    logic [WD_W-1:0] wd_q;
    logic [WD_W-1:0] wd_d;
    logic            dime_jam_q;
    logic            dime_jam_d;
    logic            nickel_jam_q;
    logic            nickel_jam_d;
    logic            in_wait;
    logic            ack_now;
    logic            wd_expired;

    // Watchdog: counts wait-state cycles without an ack. An ack on the
    // final watchdog cycle still wins over the timeout. A jam raised in the
    // same cycle as a refill of that coin stays set.
    always_comb begin
        in_wait        = (state_q == ST_DIME_WAIT) || (state_q == ST_NICKEL_WAIT);
        ack_now        = dime_dec || nickel_dec;
        wd_expired     = in_wait && !ack_now && (wd_q == WD_LAST);
        dime_timeout   = wd_expired && (state_q == ST_DIME_WAIT);
        nickel_timeout = wd_expired && (state_q == ST_NICKEL_WAIT);
        wd_d           = (in_wait && !ack_now && !wd_expired) ? (wd_q + 1'b1) : '0;

        dime_jam_d = dime_jam_q;
        if (dime_timeout) begin
            dime_jam_d = 1'b1;
        end else if (refill_valid && (refill_dimes != '0)) begin
            dime_jam_d = 1'b0;
        end

        nickel_jam_d = nickel_jam_q;
        if (nickel_timeout) begin
            nickel_jam_d = 1'b1;
        end else if (refill_valid && (refill_nickels != '0)) begin
            nickel_jam_d = 1'b0;
        end
    end

    // Watchdog counter and sticky jam flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q         <= '0;
            dime_jam_q   <= 1'b0;
            nickel_jam_q <= 1'b0;
        end else begin
            wd_q         <= wd_d;
            dime_jam_q   <= dime_jam_d;
            nickel_jam_q <= nickel_jam_d;
        end
    end

    // A jammed hopper looks empty to coin selection.
    assign dime_avail   = dime_nz && !dime_jam_q;
    assign nickel_avail = nickel_nz && !nickel_jam_q;
    assign dime_jam     = dime_jam_q;
    assign nickel_jam   = nickel_jam_q;
`else
    assign dime_timeout   = 1'b0;
    assign nickel_timeout = 1'b0;
    assign dime_avail     = dime_nz;
    assign nickel_avail   = nickel_nz;
`endif

    // Payout FSM: pick the largest affordable coin, wait for its ack,
    // repeat until nothing more can be paid, then pulse done.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        shortfall_d = shortfall_q;

        case (state_q)
            ST_IDLE: begin
                if (change_valid) begin
                    remaining_d = change_amt;
                    if (change_amt == '0) begin
                        shortfall_d = '0;
                        state_d     = ST_DONE;
                    end else begin
                        state_d = ST_SEL;
                    end
                end
            end
            ST_SEL: begin
                if ((remaining_q >= DIME_AMT) && dime_avail) begin
                    state_d = ST_DIME_WAIT;
                end else if ((remaining_q >= NICKEL_AMT) && nickel_avail) begin
                    state_d = ST_NICKEL_WAIT;
                end else begin
                    shortfall_d = remaining_q;
                    state_d     = ST_DONE;
                end
            end
            ST_DIME_WAIT: begin
                if (dime_dec) begin
                    remaining_d = remaining_q - DIME_AMT;
                    state_d     = ST_SEL;
                end else if (dime_timeout) begin
                    state_d = ST_SEL;
                end
            end
            ST_NICKEL_WAIT: begin
                if (nickel_dec) begin
                    remaining_d = remaining_q - NICKEL_AMT;
                    state_d     = ST_SEL;
                end else if (nickel_timeout) begin
                    state_d = ST_SEL;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state and registered outputs; requests and done follow the
    // next state so they appear on the same edge the state changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            remaining_q  <= '0;
            shortfall_q  <= '0;
            dime_req_q   <= 1'b0;
            nickel_req_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            shortfall_q  <= shortfall_d;
            dime_req_q   <= (state_d == ST_DIME_WAIT);
            nickel_req_q <= (state_d == ST_NICKEL_WAIT);
            done_q       <= (state_d == ST_DONE);
        end
    end

    coin_inventory #(
        .INV_W (INV_W),
        .INIT  (DIME_INIT)
    ) u_dime_inv (
        .clk          (clk),
        .rst_n        (rst_n),
        .refill_valid (refill_valid),
        .refill_amt   (refill_dimes),
        .dec          (dime_dec),
        .cnt          (dime_cnt),
        .nonzero      (dime_nz)
    );

    coin_inventory #(
        .INV_W (INV_W),
        .INIT  (NICKEL_INIT)
    ) u_nickel_inv (
        .clk          (clk),
        .rst_n        (rst_n),
        .refill_valid (refill_valid),
        .refill_amt   (refill_nickels),
        .dec          (nickel_dec),
        .cnt          (nickel_cnt),
        .nonzero      (nickel_nz)
    );

    assign change_ready      = (state_q == ST_IDLE);
    assign dime_req          = dime_req_q;
    assign nickel_req        = nickel_req_q;
    assign done              = done_q;
    assign shortfall         = shortfall_q;
    assign exact_change_only = (nickel_cnt == '0);

endmodule

// File: tb/tb_vend_change_sequencer.sv
// Self-checking bench for vend_change_sequencer: directed steps plus
// randomized payouts/refills, checked against a greedy arithmetic model.
module tb_vend_change_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       change_valid;
    logic [4:0] change_amt;
    logic       change_ready;
    logic       dime_req;
    logic       dime_ack;
    logic       nickel_req;
    logic       nickel_ack;
    logic       refill_valid;
    logic [5:0] refill_dimes;
    logic [5:0] refill_nickels;
    logic [5:0] dime_cnt;
    logic [5:0] nickel_cnt;
    logic       exact_change_only;
    logic       done;
    logic [4:0] shortfall;
`ifdef HOPPER_TIMEOUT_EN
    logic       dime_jam;
    logic       nickel_jam;
`endif

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: inventory and dime jam flag.
    int m_dc;
    int m_nc;
    bit m_djam;

    vend_change_sequencer #(
        .CREDIT_W    (5),
        .INV_W       (6),
        .DIME_INIT   (20),
        .NICKEL_INIT (20)
`ifdef HOPPER_TIMEOUT_EN
        ,
        .TIMEOUT_CYC (8)
`endif
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .change_valid      (change_valid),
        .change_amt        (change_amt),
        .change_ready      (change_ready),
        .dime_req          (dime_req),
        .dime_ack          (dime_ack),
        .nickel_req        (nickel_req),
        .nickel_ack        (nickel_ack),
        .refill_valid      (refill_valid),
        .refill_dimes      (refill_dimes),
        .refill_nickels    (refill_nickels),
        .dime_cnt          (dime_cnt),
        .nickel_cnt        (nickel_cnt),
        .exact_change_only (exact_change_only),
        .done              (done),
        .shortfall         (shortfall)
`ifdef HOPPER_TIMEOUT_EN
        ,
        .dime_jam          (dime_jam),
        .nickel_jam        (nickel_jam)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL global_timeout: observed no finish, required finish within 90000 cycles");
        $fatal(1, "bench time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    function automatic int sat63(input int v);
        return (v > 63) ? 63 : v;
    endfunction

    // Inventory and flag outputs against the model.
    task automatic chk_inv(input string tag);
        chk({tag, "_dime_cnt"}, 32'(dime_cnt), m_dc);
        chk({tag, "_nickel_cnt"}, 32'(nickel_cnt), m_nc);
        chk({tag, "_exact_change"}, 32'(exact_change_only), (m_nc == 0) ? 1 : 0);
`ifdef HOPPER_TIMEOUT_EN
        chk({tag, "_dime_jam"}, 32'(dime_jam), 32'(m_djam));
`endif
    endtask

    // Model: dimes while at least two units are owed and dimes are usable,
    // then nickels; whatever is left is the shortfall. A nickel ack paired
    // with a 5-nickel refill nets +4, saturating at 63.
    task automatic model_payout(input int amt, input bit dime_ok, input bit refill_on_nack,
                                output int ed, output int en, output int esf);
        int r;
        r  = amt;
        ed = 0;
        en = 0;
        while (r >= 2 && dime_ok && m_dc > 0) begin
            r  -= 2;
            m_dc--;
            ed++;
        end
        while (r >= 1 && m_nc > 0) begin
            r--;
            en++;
            m_nc = refill_on_nack ? sat63(m_nc + 4) : (m_nc - 1);
        end
        esf = r;
    endtask

    // Idle refill of both hoppers for one cycle.
    task automatic do_refill(input int rd, input int rn);
        @(negedge clk);
        refill_valid   = 1'b1;
        refill_dimes   = 6'(rd);
        refill_nickels = 6'(rn);
        @(negedge clk);
        refill_valid   = 1'b0;
        refill_dimes   = '0;
        refill_nickels = '0;
        m_dc = sat63(m_dc + rd);
        m_nc = sat63(m_nc + rn);
        if (rd != 0) m_djam = 1'b0;
    endtask

    // Drive one payout and act as both hoppers until done (bounded).
    task automatic payout(input int amt, input int max_dly, input bit dime_hold, input bit refill_on_nack,
                          output int nd, output int nn, output int sf, output bit seen_done,
                          output bit both_hi, output int hold_cyc);
        int dwait;
        int nwait;
        int dtgt;
        int ntgt;
        nd = 0; nn = 0; sf = -1; seen_done = 0; both_hi = 0; hold_cyc = 0;
        dwait = 0; nwait = 0;
        dtgt = $urandom_range(max_dly, 0);
        ntgt = $urandom_range(max_dly, 0);
        @(negedge clk);
        change_valid = 1'b1;
        change_amt   = 5'(amt);
        @(posedge clk);
        #1;
        change_valid = 1'b0;
        for (int c = 0; c < 500 && !seen_done; c++) begin
            @(negedge clk);
            dime_ack = 1'b0; nickel_ack = 1'b0; change_valid = 1'b0;
            refill_valid = 1'b0; refill_dimes = '0; refill_nickels = '0;
            if (dime_req && nickel_req) both_hi = 1;
            if (done) begin
                seen_done = 1;
                sf = int'(shortfall);
            end else begin
                // Requests while busy must be ignored.
                if (!change_ready) begin
                    change_valid = 1'($urandom_range(1, 0));
                    change_amt   = 5'($urandom);
                end
                if (dime_req) begin
                    if (dime_hold) begin
                        hold_cyc++;
                    end else if (dwait == dtgt) begin
                        dime_ack = 1'b1; nd++; dwait = 0; dtgt = $urandom_range(max_dly, 0);
                    end else begin
                        dwait++;
                    end
                end else begin
                    dime_ack = ($urandom_range(3, 0) == 0);
                end
                if (nickel_req) begin
                    if (nwait == ntgt) begin
                        nickel_ack = 1'b1; nn++; nwait = 0; ntgt = $urandom_range(max_dly, 0);
                        if (refill_on_nack) begin
                            refill_valid = 1'b1; refill_nickels = 6'd5;
                        end
                    end else begin
                        nwait++;
                    end
                end else begin
                    nickel_ack = ($urandom_range(3, 0) == 0);
                end
            end
        end
        dime_ack = 1'b0; nickel_ack = 1'b0; change_valid = 1'b0;
        refill_valid = 1'b0; refill_dimes = '0; refill_nickels = '0;
    endtask

    // Full transaction: model, drive, compare, one line printed.
    task automatic txn(input string tag, input int amt, input int max_dly, input bit dime_hold,
                       input bit refill_on_nack);
        int ed, en, esf, nd, nn, sf, hold_cyc;
        bit seen_done, both_hi;
        model_payout(amt, !dime_hold && !m_djam, refill_on_nack, ed, en, esf);
        payout(amt, max_dly, dime_hold, refill_on_nack, nd, nn, sf, seen_done, both_hi, hold_cyc);
        chk({tag, "_done_seen"}, 32'(seen_done), 1);
        chk({tag, "_dime_coins"}, nd, ed);
        chk({tag, "_nickel_coins"}, nn, en);
        chk({tag, "_shortfall"}, sf, esf);
        chk({tag, "_req_overlap"}, 32'(both_hi), 0);
        if (dime_hold) begin
            chk({tag, "_dime_req_cycles"}, hold_cyc, 8);
            m_djam = 1'b1;
        end
        chk_inv(tag);
        $display("txn %s amt=%0d dimes=%0d nickels=%0d shortfall=%0d inv=%0d/%0d",
                 tag, amt, nd, nn, sf, dime_cnt, nickel_cnt);
    endtask

    initial begin
        rst_n = 1'b0;
        change_valid = 1'b0; change_amt = '0;
        dime_ack = 1'b0; nickel_ack = 1'b0;
        refill_valid = 1'b0; refill_dimes = '0; refill_nickels = '0;
        m_dc = 20; m_nc = 20; m_djam = 1'b0;

        // Reset defaults.
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(change_ready), 1);
        chk("rst_dime_req", 32'(dime_req), 0);
        chk("rst_nickel_req", 32'(nickel_req), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_shortfall", 32'(shortfall), 0);
        chk_inv("rst");
        $display("txn reset inv=%0d/%0d ready=%0d", dime_cnt, nickel_cnt, change_ready);

        // amt 3, prompt acks: one dime then one nickel, 19/19.
        txn("amt3", 3, 0, 1'b0, 1'b0);

        // Reset mid-payout: requests drop at once, inventory reloads, no done.
        @(negedge clk);
        change_valid = 1'b1;
        change_amt   = 5'd10;
        @(posedge clk);
        #1;
        change_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_dime_req_up", 32'(dime_req), 1);
        rst_n = 1'b0;
        #1;
        m_dc = 20; m_nc = 20; m_djam = 1'b0;
        chk("mid_rst_dime_req", 32'(dime_req), 0);
        chk("mid_rst_nickel_req", 32'(nickel_req), 0);
        chk("mid_rst_ready", 32'(change_ready), 1);
        chk_inv("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid_rst_no_done", 32'(done), 0);
        end
        $display("txn reset_mid_payout inv=%0d/%0d", dime_cnt, nickel_cnt);

        // Refill saturation: 20 + 63 dimes clamps at 63.
        do_refill(63, 0);
        chk_inv("refill_sat");
        $display("txn refill_sat inv=%0d/%0d", dime_cnt, nickel_cnt);

`ifdef HOPPER_TIMEOUT_EN
        // Dime hopper never acks: watchdog jams it, nickels pay instead.
        txn("timeout", 2, 0, 1'b1, 1'b0);
        do_refill(1, 0);
        chk_inv("jam_clear");
        $display("txn jam_clear inv=%0d/%0d", dime_cnt, nickel_cnt);
`endif

        // Refill arriving on the nickel ack edge: both applied.
        txn("refill_on_ack", 1, 1, 1'b0, 1'b1);

        // Randomized payouts with occasional idle refills.
        for (int t = 0; t < 30; t++) begin
            if ($urandom_range(3, 0) == 0) begin
                do_refill($urandom_range(15, 0), $urandom_range(15, 0));
                chk_inv("rand_refill");
                $display("txn rand_refill inv=%0d/%0d", dime_cnt, nickel_cnt);
            end
            txn("rand", $urandom_range(31, 0), 3, 1'b0, 1'b0);
        end

        // Drain both hoppers completely.
        for (int t = 0; t < 40 && (m_dc > 0 || m_nc > 0); t++) begin
            txn("drain", 31, 2, 1'b0, 1'b0);
        end

        // No dimes: four nickels pay 4 units.
        do_refill(0, 4);
        txn("no_dimes", 4, 1, 1'b0, 1'b0);

        // One nickel against 3 owed: shortfall 2, exact change only.
        do_refill(0, 1);
        txn("short", 3, 0, 1'b0, 1'b0);

        // Zero amount completes straight away.
        txn("zero", 0, 0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
